grant_ack_tracker: RTL and testbench
====================================

// Module: grant_ack_tracker
// PURPOSE
// - Sits on the inbound TileLink D channel, directly upstream of the E-channel GrantAck source stage.
// - Passes every D beat through to the response consumer and counts beats of multi-beat messages.
// - On the last beat of each Grant/GrantData, queues that message's sink ID as a GrantAck request
//   for the downstream E-source stage.
// - Throttles D intake when the ack queue is full, so no GrantAck is ever dropped.
// PARAMETERS
// - SINK_BITS     3   width of d_sink / req_bits_sink
// - SOURCE_BITS   4   width of d_source
// - DATA_BITS     64  beat width; beat bytes BB = DATA_BITS/8
// - ACK_DEPTH     2   pending-GrantAck FIFO entries (power of 2, >=2)
// PORTS
// - clock              in   1            sole clock, rising edge
// - reset              in   1            synchronous, active-low (0 = reset)
// - io_d_ready         out  1            D beat accepted this cycle when high with io_d_valid
// - io_d_valid         in   1            D beat present
// - io_d_bits_opcode   in   3            0 AccessAck, 1 AccessAckData, 4 Grant, 5 GrantData, 6 ReleaseAck
// - io_d_bits_size     in   4            log2(message bytes)
// - io_d_bits_source   in   SOURCE_BITS  transaction source
// - io_d_bits_sink     in   SINK_BITS    sink ID to return in GrantAck
// - io_d_bits_denied   in   1            denied flag (forwarded)
// - io_d_bits_data     in   DATA_BITS    beat payload
// - io_resp_ready      in   1            consumer ready
// - io_resp_valid      out  1            forwarded beat valid
// - io_resp_bits_*     out  -            opcode/size/source/sink/denied/data, unchanged from D
// - io_resp_bits_last  out  1            beat is final beat of its message
// - io_req_ready       in   1            E-source stage ready
// - io_req_valid       out  1            GrantAck request pending
// - io_req_bits_sink   out  SINK_BITS    sink of oldest pending Grant
// BEHAVIOUR
// - Reset (reset==0 at rising edge):
//   - beat counter = 0; ack FIFO emptied.
//   - While reset is low: io_req_valid = 0, io_d_ready = 0, io_resp_valid = 0.
//   - Reset mid-message discards partial beat count and all queued acks.
// - Beat count:
//   - beats = 2^(size - log2 BB) for opcodes 1 and 5 when size > log2 BB; otherwise beats = 1.
//   - All other opcodes are always 1 beat, regardless of size.
//   - Counter is 8 bits; messages over 256 beats are illegal (simulation assertion).
// - last = (counter == beats-1). On a fire (d_valid & d_ready): counter <= last ? 0 : counter+1.
//   Size and opcode are sampled on every beat and must stay constant within a message.
// - Flow-through, zero latency: io_resp_valid = io_d_valid & gate; io_d_ready = io_resp_ready & gate;
//   resp bits = d bits.
// - gate = 0 only when the current beat is the last beat of opcode 4/5 and the ack FIFO is full;
//   otherwise gate = 1.
//   - Non-last beats and non-Grant messages are never gated.
// - Ack enqueue: a fire on the last beat of opcode 4 or 5 writes d_sink into the FIFO, including
//   when denied=1.
// - Ack dequeue: io_req_valid = FIFO not empty; io_req_bits_sink = head entry;
//   pop on io_req_valid & io_req_ready.
// - Latency: ack becomes visible on io_req_valid the cycle after the last-beat fire (no bypass).
// - Simultaneous push and pop: allowed when not full, and the count is unchanged.
//   When full, push is blocked by gate; the pop frees a slot only for the next cycle.
// - Pointers wrap modulo ACK_DEPTH. Full/empty come from a registered count 0..ACK_DEPTH.
// - Order: acks are issued strictly in Grant-completion order.
// TESTING
// - Reset: hold reset=0 for 3 cycles with d_valid=1 -> d_ready=0, resp_valid=0, req_valid=0.
//   Release -> counter 0, FIFO empty.
// - Grant, 1 beat: opcode=4, size=6, sink=5, resp_ready=1 -> resp_last=1 same cycle;
//   next cycle req_valid=1, sink=5; pops on req_ready.
// - GrantData, 8 beats: opcode=5, size=6, BB=8 -> resp_last only on beat 8;
//   exactly one ack (sink=2) one cycle after beat 8.
// - AccessAckData, 8 beats: opcode=1, size=6 -> last on beat 8; req_valid stays 0.
//   ReleaseAck with size=6 -> single beat, no ack.
// - Full FIFO: req_ready=0, then Grants with sink=1 and sink=3 -> FIFO full;
//   third Grant (sink=6) held with d_ready=0.
//   - Raise req_ready -> sink 1 pops; the sink=6 Grant is accepted the following cycle.
//   - Acks then come out in order 3, 6.
// - Denied / reset mid-message: GrantData with denied=1 -> ack still issued.
//   Reset after beat 3 of 8 -> next message counts from beat 0, and no stale ack remains.

Source files
------------

// File: rtl/grant_ack_tracker.sv
// grant_ack_tracker: forwards TileLink D beats to the response consumer, finds the last beat of
// each message, and queues one GrantAck sink per completed Grant/GrantData for the E-source stage.
module grant_ack_tracker #(
    parameter int SINK_BITS   = 3,
    parameter int SOURCE_BITS = 4,
    parameter int DATA_BITS   = 64,
    parameter int ACK_DEPTH   = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_d_ready,
    input  logic                   io_d_valid,
    input  logic [2:0]             io_d_bits_opcode,
    input  logic [3:0]             io_d_bits_size,
    input  logic [SOURCE_BITS-1:0] io_d_bits_source,
    input  logic [SINK_BITS-1:0]   io_d_bits_sink,
    input  logic                   io_d_bits_denied,
    input  logic [DATA_BITS-1:0]   io_d_bits_data,
    input  logic                   io_resp_ready,
    output logic                   io_resp_valid,
    output logic [2:0]             io_resp_bits_opcode,
    output logic [3:0]             io_resp_bits_size,
    output logic [SOURCE_BITS-1:0] io_resp_bits_source,
    output logic [SINK_BITS-1:0]   io_resp_bits_sink,
    output logic                   io_resp_bits_denied,
    output logic [DATA_BITS-1:0]   io_resp_bits_data,
    output logic                   io_resp_bits_last,
    input  logic                   io_req_ready,
    output logic                   io_req_valid,
    output logic [SINK_BITS-1:0]   io_req_bits_sink
);
    localparam int LG_BB = $clog2(DATA_BITS / 8);
    localparam int PTR_W = $clog2(ACK_DEPTH);
    localparam int CNT_W = $clog2(ACK_DEPTH + 1);

    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] OP_GRANT           = 3'd4;
    localparam logic [2:0] OP_GRANT_DATA      = 3'd5;

    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     ack_cnt_q, ack_cnt_d;
    logic [SINK_BITS-1:0] ack_mem_q [ACK_DEPTH];
    logic [SINK_BITS-1:0] ack_mem_d [ACK_DEPTH];

    logic        has_data, is_grant, multi_beat, last, ack_full;
    logic        gate, fire, push, pop;
    logic [3:0]  beat_shift;
    logic [15:0] beats_m1;

    always_comb begin
        has_data   = (io_d_bits_opcode == OP_ACCESS_ACK_DATA) || (io_d_bits_opcode == OP_GRANT_DATA);
        is_grant   = (io_d_bits_opcode == OP_GRANT) || (io_d_bits_opcode == OP_GRANT_DATA);
        beat_shift = io_d_bits_size - 4'(LG_BB);
        multi_beat = has_data && (io_d_bits_size > 4'(LG_BB));
        beats_m1   = multi_beat ? ((16'd1 << beat_shift) - 16'd1) : 16'd0;
        last       = ({8'd0, beat_cnt_q} == beats_m1);
        ack_full   = (ack_cnt_q == CNT_W'(ACK_DEPTH));

        // NOTE: reset is folded into the handshakes so they stay low even before the first reset edge.
        gate          = reset && !(is_grant && last && ack_full);
        io_d_ready    = io_resp_ready && gate;
        io_resp_valid = io_d_valid && gate;
        fire          = io_d_valid && io_d_ready;
        push          = fire && is_grant && last;

        io_req_valid     = reset && (ack_cnt_q != '0);
        io_req_bits_sink = ack_mem_q[rd_ptr_q];
        pop              = io_req_valid && io_req_ready;
    end

    assign io_resp_bits_opcode = io_d_bits_opcode;
    assign io_resp_bits_size   = io_d_bits_size;
    assign io_resp_bits_source = io_d_bits_source;
    assign io_resp_bits_sink   = io_d_bits_sink;
    assign io_resp_bits_denied = io_d_bits_denied;
    assign io_resp_bits_data   = io_d_bits_data;
    assign io_resp_bits_last   = last;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (fire) begin
            beat_cnt_d = last ? 8'd0 : beat_cnt_q + 8'd1;
        end

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ack_mem_d = ack_mem_q;
        if (push) begin
            ack_mem_d[wr_ptr_q] = io_d_bits_sink;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        ack_cnt_d = ack_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            beat_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ack_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    // NOTE: the ack payload is not reset; entries are only read while ack_cnt_q marks them valid.
    always_ff @(posedge clock) begin
        ack_mem_q <= ack_mem_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset && io_d_valid) begin
            assert (beats_m1 < 16'd256);
        end
    end
`endif

endmodule

// File: tb/tb_grant_ack_tracker.sv
// Self-checking bench for grant_ack_tracker: message-level reference model feeding scoreboards,
// with a negedge monitor that compares every forwarded beat, every GrantAck and the handshakes.
module tb_grant_ack_tracker;
    localparam int ACK_DEPTH = 2;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [3:0]  source;
        logic [2:0]  sink;
        logic        denied;
        logic [63:0] data;
        logic        last;
    } resp_t;

    logic        clock;
    logic        reset;
    logic        io_d_ready;
    logic        io_d_valid;
    logic [2:0]  io_d_bits_opcode;
    logic [3:0]  io_d_bits_size;
    logic [3:0]  io_d_bits_source;
    logic [2:0]  io_d_bits_sink;
    logic        io_d_bits_denied;
    logic [63:0] io_d_bits_data;
    logic        io_resp_ready;
    logic        io_resp_valid;
    logic [2:0]  io_resp_bits_opcode;
    logic [3:0]  io_resp_bits_size;
    logic [3:0]  io_resp_bits_source;
    logic [2:0]  io_resp_bits_sink;
    logic        io_resp_bits_denied;
    logic [63:0] io_resp_bits_data;
    logic        io_resp_bits_last;
    logic        io_req_ready;
    logic        io_req_valid;
    logic [2:0]  io_req_bits_sink;

    grant_ack_tracker #(
        .SINK_BITS(3), .SOURCE_BITS(4), .DATA_BITS(64), .ACK_DEPTH(ACK_DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .io_d_ready(io_d_ready), .io_d_valid(io_d_valid),
        .io_d_bits_opcode(io_d_bits_opcode), .io_d_bits_size(io_d_bits_size),
        .io_d_bits_source(io_d_bits_source), .io_d_bits_sink(io_d_bits_sink),
        .io_d_bits_denied(io_d_bits_denied), .io_d_bits_data(io_d_bits_data),
        .io_resp_ready(io_resp_ready), .io_resp_valid(io_resp_valid),
        .io_resp_bits_opcode(io_resp_bits_opcode), .io_resp_bits_size(io_resp_bits_size),
        .io_resp_bits_source(io_resp_bits_source), .io_resp_bits_sink(io_resp_bits_sink),
        .io_resp_bits_denied(io_resp_bits_denied), .io_resp_bits_data(io_resp_bits_data),
        .io_resp_bits_last(io_resp_bits_last),
        .io_req_ready(io_req_ready), .io_req_valid(io_req_valid),
        .io_req_bits_sink(io_req_bits_sink)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    resp_t      resp_q[$];
    logic [2:0] ack_q[$];
    int         occ = 0;
    logic       mon_en = 0;
    logic       drv_last_grant = 0;
    logic       mon_gate;
    logic       mon_fire;
    resp_t      act_r;
    resp_t      exp_r;
    int         resp_mode = 1;   // 0 low, 1 high, 2 random
    int         req_mode = 1;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    initial begin
        io_resp_ready = 1;
        forever begin
            @(posedge clock);
            #2;
            case (resp_mode)
                0:       io_resp_ready = 0;
                1:       io_resp_ready = 1;
                default: io_resp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        io_req_ready = 1;
        forever begin
            @(posedge clock);
            #2;
            case (req_mode)
                0:       io_req_ready = 0;
                1:       io_req_ready = 1;
                default: io_req_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    // Monitor: reference gating/occupancy model plus the two scoreboards.
    always @(negedge clock) begin
        if (mon_en) begin
            mon_gate = !(drv_last_grant && (occ == ACK_DEPTH));
            check("resp_valid", io_resp_valid, io_d_valid && mon_gate);
            if (io_d_valid) check("d_ready", io_d_ready, io_resp_ready && mon_gate);
            check("req_valid", io_req_valid, occ != 0);
            if (io_resp_valid && io_resp_ready) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", io_resp_valid, 1'b0);
                end else begin
                    exp_r        = resp_q.pop_front();
                    act_r.op     = io_resp_bits_opcode;
                    act_r.size   = io_resp_bits_size;
                    act_r.source = io_resp_bits_source;
                    act_r.sink   = io_resp_bits_sink;
                    act_r.denied = io_resp_bits_denied;
                    act_r.data   = io_resp_bits_data;
                    act_r.last   = io_resp_bits_last;
                    check("resp_beat", act_r, exp_r);
                end
            end
            if (io_req_valid && io_req_ready) begin
                if (ack_q.size() == 0) check("ack_unexpected", io_req_valid, 1'b0);
                else                   check("ack_sink", io_req_bits_sink, ack_q.pop_front());
            end
            mon_fire = io_d_valid && io_resp_ready && mon_gate;
            if (occ != 0 && io_req_ready) occ--;
            if (mon_fire && drv_last_grant) occ++;
        end
    end

    // Drives one message; stop_after >= 0 abandons it after that many accepted beats.
    task automatic send_msg(input logic [2:0] op, input logic [3:0] size, input logic [2:0] sink,
                            input logic den, input int stop_after, input int max_gap,
                            output int stalls);
        int    beats;
        int    budget;
        resp_t e;
        logic  grant;
        grant  = (op == 3'd4) || (op == 3'd5);
        beats  = ((op == 3'd1 || op == 3'd5) && size > 4'd3) ? (1 << (int'(size) - 3)) : 1;
        stalls = 0;
        for (int i = 0; i < beats; i++) begin
            if (i == stop_after) begin
                io_d_valid = 0;
                return;
            end
            if (max_gap > 0) begin
                io_d_valid = 0;
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clock);
                    #1;
                end
            end
            e.op     = op;
            e.size   = size;
            e.source = 4'($urandom);
            e.sink   = sink;
            e.denied = den;
            e.data   = {$urandom, $urandom};
            e.last   = (i == beats - 1);
            io_d_bits_opcode = e.op;
            io_d_bits_size   = e.size;
            io_d_bits_source = e.source;
            io_d_bits_sink   = e.sink;
            io_d_bits_denied = e.denied;
            io_d_bits_data   = e.data;
            io_d_valid       = 1;
            drv_last_grant   = grant && e.last;
            resp_q.push_back(e);
            if (grant && e.last) ack_q.push_back(sink);
            budget = 0;
            @(negedge clock);
            while (!io_d_ready) begin
                stalls++;
                budget++;
                if (budget > 2000) timeout_fail("d_beat_accept");
                @(negedge clock);
            end
            @(posedge clock);
            #1;
        end
        io_d_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_drained();
        int budget;
        budget = 0;
        while (occ != 0 || ack_q.size() != 0 || resp_q.size() != 0) begin
            budget++;
            if (budget > 500) timeout_fail("drain");
            @(posedge clock);
            #1;
        end
    endtask

    int         stalls;
    logic [2:0] rop;
    logic [3:0] rsize;

    initial begin
        reset            = 0;
        io_d_valid       = 1;
        io_d_bits_opcode = 3'd4;
        io_d_bits_size   = 4'd0;
        io_d_bits_source = 4'd0;
        io_d_bits_sink   = 3'd5;
        io_d_bits_denied = 0;
        io_d_bits_data   = '0;

        // Reset held with a pending beat: every handshake must stay low.
        repeat (3) begin
            @(negedge clock);
            check("rst_d_ready", io_d_ready, 1'b0);
            check("rst_resp_valid", io_resp_valid, 1'b0);
            check("rst_req_valid", io_req_valid, 1'b0);
        end
        @(posedge clock);
        #1;
        reset      = 1;
        io_d_valid = 0;
        mon_en     = 1;

        // Single-beat Grant, 8-beat GrantData, 8-beat AccessAckData, ReleaseAck.
        send_msg(3'd4, 4'd6, 3'd5, 1'b0, -1, 0, stalls);
        idle(3);
        send_msg(3'd5, 4'd6, 3'd2, 1'b0, -1, 0, stalls);
        idle(3);
        send_msg(3'd1, 4'd6, 3'd0, 1'b0, -1, 0, stalls);
        send_msg(3'd6, 4'd6, 3'd3, 1'b0, -1, 0, stalls);
        idle(3);
        wait_drained();

        // Fill the ack FIFO, then a third Grant must wait for a pop.
        req_mode = 0;
        send_msg(3'd4, 4'd0, 3'd1, 1'b0, -1, 0, stalls);
        send_msg(3'd4, 4'd0, 3'd3, 1'b0, -1, 0, stalls);
        fork
            send_msg(3'd4, 4'd0, 3'd6, 1'b0, -1, 0, stalls);
            begin
                repeat (3) @(posedge clock);
                #1;
                req_mode = 1;
            end
        join
        check("full_stall_cycles", stalls, 4);
        wait_drained();

        // Reset mid-message with an ack still queued.
        req_mode = 0;
        send_msg(3'd4, 4'd0, 3'd4, 1'b0, -1, 0, stalls);
        send_msg(3'd5, 4'd6, 3'd7, 1'b0, 3, 0, stalls);
        mon_en = 0;
        reset  = 0;
        @(negedge clock);
        check("midrst_req_valid", io_req_valid, 1'b0);
        check("midrst_resp_valid", io_resp_valid, 1'b0);
        idle(2);
        resp_q.delete();
        ack_q.delete();
        occ      = 0;
        reset    = 1;
        req_mode = 1;
        mon_en   = 1;
        send_msg(3'd5, 4'd6, 3'd2, 1'b1, -1, 0, stalls);
        wait_drained();

        // Randomized traffic with random back-pressure on both sides.
        resp_mode = 2;
        req_mode  = 2;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0:       rop = 3'd0;
                1:       rop = 3'd1;
                2:       rop = 3'd4;
                3:       rop = 3'd5;
                default: rop = 3'd6;
            endcase
            rsize = (rop == 3'd1 || rop == 3'd5) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            send_msg(rop, rsize, 3'($urandom), 1'($urandom), -1, 2, stalls);
        end
        resp_mode = 1;
        req_mode  = 1;
        wait_drained();
        idle(2);
        check("end_req_valid", io_req_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
